// File: rtl/binary_pkg.sv
// Shared luma weights and gray conversion for the threshold controller and the pixel binarizer.
// Both sides call gray() so their luma values always match.
package binary_pkg;

   localparam int unsigned LUMA_WR    = 5;
   localparam int unsigned LUMA_WG    = 9;
   localparam int unsigned LUMA_WB    = 2;
   localparam int unsigned LUMA_SHIFT = 4;

   localparam logic [7:0] INIT_THR_DEF = 8'd128;

   typedef enum logic [1:0] {
      StAccum,
      StDivide,
      StUpdate
   } thr_state_e;

   // Weights sum to 16, so 12 bits cover 16*255 and the shifted result fits 8 bits.
   function automatic logic [7:0] gray(input logic [23:0] rgb);
      logic [11:0] acc;
      logic [11:0] shifted;
      acc = 12'(LUMA_WR) * {4'b0, rgb[23:16]}
          + 12'(LUMA_WG) * {4'b0, rgb[15:8]}
          + 12'(LUMA_WB) * {4'b0, rgb[7:0]};
      shifted = acc >> LUMA_SHIFT;
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; the start cycle already computes the first bit.
// start restarts unconditionally, abort drops a running divide without asserting done.
module seq_divider #(
   parameter int unsigned DVD_W = 28,
   parameter int unsigned DVS_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);

   localparam int unsigned CW = $clog2(DVD_W + 1);

   logic [DVS_W-1:0] rem_q, src_rem;
   logic [DVD_W-1:0] quo_q, src_quo, nxt_quo;
   logic [DVS_W-1:0] dvs_q, src_dvs;
   logic [DVS_W:0]   trial, nxt_rem;
   logic [CW-1:0]    cnt_q;
   logic             run_q;
   logic             q_bit;

   always_comb begin
      src_rem = start ? '0 : rem_q;
      src_quo = start ? dividend : quo_q;
      src_dvs = start ? divisor : dvs_q;
      trial   = {src_rem, src_quo[DVD_W-1]};
      if (trial >= {1'b0, src_dvs}) begin
         nxt_rem = trial - {1'b0, src_dvs};
         q_bit   = 1'b1;
      end else begin
         nxt_rem = trial;
         q_bit   = 1'b0;
      end
      nxt_quo = {src_quo[DVD_W-2:0], q_bit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         rem_q <= nxt_rem[DVS_W-1:0];
         quo_q <= nxt_quo;
         dvs_q <= divisor;
         cnt_q <= CW'(DVD_W - 1);
         run_q <= 1'b1;
      end else if (abort) begin
         run_q <= 1'b0;
      end else if (run_q) begin
         if (cnt_q != '0) begin
            rem_q <= nxt_rem[DVS_W-1:0];
            quo_q <= nxt_quo;
            cnt_q <= cnt_q - 1'b1;
         end else begin
            run_q <= 1'b0;
         end
      end
   end

   assign busy     = run_q;
   assign done     = run_q && (cnt_q == '0) && !start && !abort;
   assign quotient = quo_q;

endmodule

// File: rtl/binary_thr_ctrl.sv
// Frame-synchronous threshold controller for the binarizer: per-frame luma mean via a
// sequential divider (auto mode) or a button-stepped manual value, applied at frame boundaries.
module binary_thr_ctrl
   import binary_pkg::*;
#(
   parameter int unsigned CNT_W    = 20,
   parameter logic [7:0]  INIT_THR = INIT_THR_DEF,
   parameter int unsigned STEP     = 4
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        vsync_i,
   input  logic        de_i,
   input  logic [23:0] rgb_i,
   input  logic        auto_en_i,
   input  logic [7:0]  offset_i,
   input  logic        btn_up_i,
   input  logic        btn_dn_i,
   output logic [7:0]  threshold_o,
   output logic        thr_valid_o,
   output logic [7:0]  mean_o,
   output logic        busy_o,
   output logic        ovf_o
);

   localparam int unsigned SUM_W = CNT_W + 8;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   thr_state_e state_q, state_d;

   logic             vsync_q, frame_edge;
   logic [SUM_W-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic [7:0]       man_q, man_d;
   logic [7:0]       thr_q, thr_d;
   logic [7:0]       mean_q, mean_d;
   logic [7:0]       off_q, off_d;
   logic             valid_q, valid_d;
   logic [7:0]       gray_px;
   logic             div_start, div_abort, div_busy, div_done;
   logic [SUM_W-1:0] quo;
   logic [7:0]       mean_clip, thr_clamp;
   logic signed [9:0] biased;

   assign frame_edge = vsync_i & ~vsync_q;
   assign gray_px    = gray(rgb_i);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         sum_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         vsync_q <= vsync_i;
         ovf_q   <= ovf_q | (cnt_q == CNT_MAX);
         // A pixel in the edge cycle already belongs to the new frame.
         if (frame_edge) begin
            sum_q <= de_i ? SUM_W'(gray_px) : '0;
            cnt_q <= de_i ? CNT_W'(1) : '0;
         end else if (de_i && cnt_q != CNT_MAX) begin
            sum_q <= sum_q + SUM_W'(gray_px);
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      man_d = man_q;
      if (btn_up_i && !btn_dn_i) begin
         man_d = (man_q > 8'(255 - STEP)) ? 8'hFF : man_q + 8'(STEP);
      end else if (btn_dn_i && !btn_up_i) begin
         man_d = (man_q < 8'(STEP)) ? 8'h00 : man_q - 8'(STEP);
      end
   end

   always_comb begin
      mean_clip = (|quo[SUM_W-1:8]) ? 8'hFF : quo[7:0];
      biased    = $signed({2'b00, mean_clip}) + $signed({{2{off_q[7]}}, off_q});
      if (biased < 0) begin
         thr_clamp = 8'h00;
      end else if (biased > 10'sd255) begin
         thr_clamp = 8'hFF;
      end else begin
         thr_clamp = biased[7:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      div_abort = 1'b0;
      thr_d     = thr_q;
      mean_d    = mean_q;
      valid_d   = 1'b0;
      off_d     = off_q;
      if (frame_edge) begin
         off_d = offset_i;
         if (auto_en_i && cnt_q != '0) begin
            div_start = 1'b1;
            state_d   = StDivide;
         end else begin
            state_d   = StAccum;
            div_abort = (state_q == StDivide);
            if (!auto_en_i) begin
               thr_d   = man_q;
               valid_d = 1'b1;
            end
         end
      end else begin
         case (state_q)
            StDivide: begin
               if (div_done) begin
                  state_d = StUpdate;
                  mean_d  = mean_clip;
                  thr_d   = thr_clamp;
                  valid_d = 1'b1;
               end
            end
            StUpdate: state_d = StAccum;
            default:  state_d = StAccum;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StAccum;
         man_q   <= INIT_THR;
         thr_q   <= INIT_THR;
         mean_q  <= '0;
         off_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         man_q   <= man_d;
         thr_q   <= thr_d;
         mean_q  <= mean_d;
         off_q   <= off_d;
         valid_q <= valid_d;
      end
   end

   seq_divider #(
      .DVD_W(SUM_W),
      .DVS_W(CNT_W)
   ) u_div (
      .clk     (pclk),
      .rst_n   (rst_n),
      .start   (div_start),
      .abort   (div_abort),
      .dividend(sum_q),
      .divisor (cnt_q),
      .busy    (div_busy),
      .done    (div_done),
      .quotient(quo)
   );

   assign threshold_o = thr_q;
   assign thr_valid_o = valid_q;
   assign mean_o      = mean_q;
   assign busy_o      = div_busy;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_binary_thr_ctrl.sv
// Bench for binary_thr_ctrl: directed frames plus random frames, every cycle compared against
// a frame-level model (per-frame sum/count, expected pulse cycle, manual value).
module tb_binary_thr_ctrl;

   localparam int SUM_W = 28;
   localparam int LAT   = SUM_W + 1;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b1;
   logic        vsync_i = 1'b0;
   logic        de_i = 1'b0;
   logic [23:0] rgb_i = '0;
   logic        auto_en_i = 1'b0;
   logic [7:0]  offset_i = '0;
   logic        btn_up_i = 1'b0;
   logic        btn_dn_i = 1'b0;
   logic [7:0]  threshold_o;
   logic        thr_valid_o;
   logic [7:0]  mean_o;
   logic        busy_o;
   logic        ovf_o;

   binary_thr_ctrl dut (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .vsync_i    (vsync_i),
      .de_i       (de_i),
      .rgb_i      (rgb_i),
      .auto_en_i  (auto_en_i),
      .offset_i   (offset_i),
      .btn_up_i   (btn_up_i),
      .btn_dn_i   (btn_dn_i),
      .threshold_o(threshold_o),
      .thr_valid_o(thr_valid_o),
      .mean_o     (mean_o),
      .busy_o     (busy_o),
      .ovf_o      (ovf_o)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;

   // Frame-level model state
   int   acc_sum, acc_cnt, man, cur_thr, cur_mean, new_thr, new_mean;
   int   exp_at, busy_until, since_e;
   logic prev_v;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_gray(input logic [23:0] c);
      return (5 * int'(c[23:16]) + 9 * int'(c[15:8]) + 2 * int'(c[7:0])) / 16;
   endfunction

   task automatic step(input logic v, input logic d, input logic [23:0] c,
                       input logic u, input logic dn);
      int m, t;
      @(posedge pclk);
      #1;
      vsync_i = v;  de_i = d;  rgb_i = c;  btn_up_i = u;  btn_dn_i = dn;
      since_e++;
      if (exp_at != 0 && since_e == exp_at) begin
         cur_thr  = new_thr;
         cur_mean = new_mean;
      end
      @(negedge pclk);
      check_eq("threshold", int'(threshold_o), cur_thr);
      check_eq("thr_valid", int'(thr_valid_o), int'(exp_at != 0 && since_e == exp_at));
      check_eq("busy", int'(busy_o), int'(since_e >= 1 && since_e <= busy_until));
      check_eq("mean", int'(mean_o), cur_mean);
      check_eq("ovf", int'(ovf_o), 0);
      if (v && !prev_v) begin
         if (!auto_en_i) begin
            exp_at = 1;  busy_until = 0;  new_thr = man;  new_mean = cur_mean;
         end else if (acc_cnt == 0) begin
            exp_at = 0;  busy_until = 0;
         end else begin
            m = acc_sum / acc_cnt;
            if (m > 255) m = 255;
            t = m + int'($signed(offset_i));
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            exp_at = LAT;  busy_until = SUM_W;  new_thr = t;  new_mean = m;
         end
         acc_sum = 0;  acc_cnt = 0;  since_e = 0;
      end
      prev_v = v;
      if (d) begin
         acc_sum += ref_gray(c);
         acc_cnt++;
      end
      if (u && !dn) man = (man + 4 > 255) ? 255 : man + 4;
      else if (dn && !u) man = (man - 4 < 0) ? 0 : man - 4;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
   endtask

   task automatic pix(input int n, input logic [23:0] c);
      repeat (n) step(1'b0, 1'b1, c, 1'b0, 1'b0);
   endtask

   task automatic fire(input logic a, input logic [7:0] off);
      auto_en_i = a;
      offset_i  = off;
      step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge pclk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("rst_threshold", int'(threshold_o), 128);
      check_eq("rst_busy", int'(busy_o), 0);
      check_eq("rst_ovf", int'(ovf_o), 0);
      check_eq("rst_valid", int'(thr_valid_o), 0);
      check_eq("rst_mean", int'(mean_o), 0);
      vsync_i = 1'b0;  de_i = 1'b0;  btn_up_i = 1'b0;  btn_dn_i = 1'b0;
      man = 128;  cur_thr = 128;  cur_mean = 0;  exp_at = 0;  busy_until = 0;
      acc_sum = 0;  acc_cnt = 0;  prev_v = 1'b0;  since_e = 1000;
      repeat (2) @(negedge pclk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [23:0] c;
      logic        u, dn;
      do_reset();
      idle(3);

      pix(16, 24'h646464);
      fire(1'b1, 8'd0);
      idle(32);
      check_eq("tp_mean100", int'(mean_o), 100);
      check_eq("tp_thr100", int'(threshold_o), 100);

      pix(8, 24'h000000);
      pix(8, 24'hFFFFFF);
      fire(1'b1, 8'd0);
      idle(32);
      check_eq("tp_thr127", int'(threshold_o), 127);

      pix(16, 24'h0A0A0A);
      fire(1'b1, 8'hEC);
      idle(32);
      check_eq("tp_clamp_lo", int'(threshold_o), 0);

      pix(16, 24'hFAFAFA);
      fire(1'b1, 8'd20);
      idle(32);
      check_eq("tp_clamp_hi", int'(threshold_o), 255);
      check_eq("tp_mean250", int'(mean_o), 250);

      do_reset();
      idle(2);
      repeat (40) step(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
      idle(3);
      check_eq("tp_man_hold", int'(threshold_o), 128);
      fire(1'b0, 8'd0);
      idle(3);
      check_eq("tp_man_sat", int'(threshold_o), 255);
      repeat (3) step(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
      fire(1'b0, 8'd0);
      idle(3);
      check_eq("tp_man_both", int'(threshold_o), 247);

      fire(1'b1, 8'd0);
      idle(32);
      check_eq("tp_empty", int'(threshold_o), 247);

      // Second edge five cycles into the divide, with four new pixels of gray 50.
      pix(16, 24'h646464);
      fire(1'b1, 8'd0);
      pix(4, 24'h323232);
      fire(1'b1, 8'd0);
      idle(32);
      check_eq("tp_abort_mean", int'(mean_o), 50);

      pix(16, 24'hC8C8C8);
      fire(1'b1, 8'd0);
      idle(10);
      do_reset();
      idle(35);

      repeat (15) begin
         int n;
         n = $urandom_range(0, 40);
         for (int i = 0; i < n; i++) begin
            u  = ($urandom % 8) == 0;
            dn = ($urandom % 8) == 0;
            if (($urandom % 4) == 0) step(1'b0, 1'b0, 24'h0, u, dn);
            c = 24'($urandom);
            step(1'b0, 1'b1, c, u, dn);
         end
         fire(1'($urandom % 2), 8'($urandom));
         idle($urandom_range(1, 35));
      end
      idle(32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
